// File: rtl/dm_lane_mem.sv
// dm_lane_mem: MEM-stage data memory with byte/half/word/dword lane access,
// sign/zero-extended loads, one-cycle registered read and error flags.
// Optional feature: define DM_RAW_BYPASS_EN to forward a same-cycle write
// into a read of the same word (otherwise the read returns pre-write data).
module dm_lane_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [1:0]        wsize,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [1:0]        rsize,
    input  logic              runsigned,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              werr,
    output logic              rerr
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int          OFF_W = $clog2(NB);
    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wlegal, rlegal;
    logic [ADDR_W-1:0] wword, rword;
    logic [IDX_W-1:0]  widx, ridx;
    logic [OFF_W-1:0]  woff, roff;
    logic [NB-1:0]     wmask;
    logic [DATA_W-1:0] wsh, rd_word, merged, shifted, keep, rdata_d;
    logic              sbit;

    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q, werr_q, rerr_q;

    // Alignment, size and range legality of an access
    function automatic logic acc_legal(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        logic ok;
        case (sz)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (a[0] == 1'b0);
            2'b10:   ok = (a[1:0] == 2'b00);
            default: ok = (DATA_W == 64) && (a[2:0] == 3'b000);
        endcase
        return ok && ((a >> OFF_W) < DEPTH_A);
    endfunction

    // Byte lanes touched by an access of size sz at byte offset off
    function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        logic [NB-1:0] base;
        case (sz)
            2'b00:   base = NB'(1);
            2'b01:   base = NB'(3);
            2'b10:   base = NB'(15);
            default: base = '1;
        endcase
        return base << off;
    endfunction

    assign wlegal  = acc_legal(waddr, wsize);
    assign rlegal  = acc_legal(raddr, rsize);
    assign wword   = waddr >> OFF_W;
    assign rword   = raddr >> OFF_W;
    assign widx    = wword[IDX_W-1:0];
    assign ridx    = rword[IDX_W-1:0];
    assign woff    = waddr[OFF_W-1:0];
    assign roff    = raddr[OFF_W-1:0];
    assign wmask   = lane_mask(wsize, woff);
    assign wsh     = wdata << {woff, 3'b000};
    assign rd_word = mem[ridx];

    // Lane-masked memory write; illegal writes and writes under reset are dropped
    always_ff @(posedge clk) begin
        if (!rst && we && wlegal) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wmask[b]) mem[widx][b*8 +: 8] <= wsh[b*8 +: 8];
            end
        end
    end

    // Word seen by the read port: memory, optionally merged with a same-word write
    always_comb begin
        merged = rd_word;
`ifdef DM_RAW_BYPASS_EN
        if (we && wlegal && (wword == rword)) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wmask[b]) merged[b*8 +: 8] = wsh[b*8 +: 8];
            end
        end
`endif
    end

    // Extract addressed bytes and sign/zero-extend to DATA_W
    always_comb begin
        shifted = merged >> {roff, 3'b000};
        keep    = '0;
        sbit    = 1'b0;
        case (rsize)
            2'b00: begin
                keep[7:0] = '1;
                sbit      = !runsigned && shifted[7];
            end
            2'b01: begin
                keep[15:0] = '1;
                sbit       = !runsigned && shifted[15];
            end
            2'b10: begin
                keep[31:0] = '1;
                sbit       = (DATA_W > 32) && !runsigned && shifted[31];
            end
            default: begin
                keep = '1;
                sbit = 1'b0;
            end
        endcase
        rdata_d = (shifted & keep) | (sbit ? ~keep : '0);
    end

    // Registered read result and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            werr_q   <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            werr_q <= we && !wlegal;
            if (re) begin
                rvalid_q <= 1'b1;
                rerr_q   <= !rlegal;
                rdata_q  <= rlegal ? rdata_d : '0;
            end else begin
                rvalid_q <= 1'b0;
                rerr_q   <= 1'b0;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign werr   = werr_q;
    assign rerr   = rerr_q;

endmodule

// File: doc/dm_lane_mem.md
# dm_lane_mem

Parametrised dual-port data memory for the pipelined CPU's MEM stage. It supports byte, half, word and (64-bit builds) doubleword access with per-lane writes and sign- or zero-extended loads. Reads have one-cycle registered latency, and misaligned or out-of-range accesses are flagged. It sits between the EX/MEM pipeline register and the MEM/WB write-back mux.

## Interface
- DATA_W, 32: memory word width in bits; legal values are 32 and 64.
- DEPTH, 1024: number of words.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state updates occur on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- we  in  1  write request.
- waddr  in  ADDR_W  write byte address.
- wsize  in  2  write size: 00 byte, 01 half, 10 word, 11 dword.
- wdata  in  DATA_W  write data, right-aligned; the low 8/16/32/64 bits are used.
- re  in  1  read request.
- raddr  in  ADDR_W  read byte address.
- rsize  in  2  read size, same encoding as wsize.
- runsigned  in  1  when 1, the load is zero-extended; when 0, sign-extended.
- rdata  out  DATA_W  load result, registered.
- rvalid  out  1  rdata updated this cycle.
- werr  out  1  one-cycle pulse: the previous cycle's write was dropped.
- rerr  out  1  one-cycle pulse, coincident with rvalid: the read was illegal.

## Operation
- OFF_W = log2(DATA_W/8).
- Word index = addr >> OFF_W.
- Byte offset = addr[OFF_W-1:0].
- Byte order is little-endian.
- Alignment rules:
  - half requires addr[0]=0
  - word requires addr[1:0]=0
  - dword requires addr[2:0]=0 and is legal only when DATA_W=64; it is illegal when DATA_W=32
- An access is illegal if it is misaligned, uses an illegal size, or has word index ≥ DEPTH.
- Write:
  - A legal write updates only the addressed lanes at the clock edge. Lane mask = ((1<<bytes)-1) << offset. wdata is shifted left by offset*8.
  - An illegal write leaves memory unchanged; werr=1 the next cycle.
- Read:
  - The addressed word is read and shifted right by offset*8, then truncated to the access size.
  - The result is then sign- or zero-extended to DATA_W.
  - A word read with DATA_W=32, or a dword read, ignores runsigned.
  - An illegal read gives rdata=0, rvalid=1, rerr=1.
- When re=0, rdata holds its last value and rvalid=0.
- Simultaneous read and write:
  - When the addresses hit different words, both are performed independently.
  - When they hit the same word, behaviour depends on DM_RAW_BYPASS_EN (see Configuration).
- Memory contents are not cleared by reset and are undefined until written.

## Timing
- Reset values, applied immediately on rst without waiting for clk: rdata=0, rvalid=0, werr=0, rerr=0.
- While rst=1:
  - Writes are suppressed.
  - Reads produce nothing.
- Read latency is 1 cycle: a request at edge N presents rdata/rvalid/rerr after edge N, stable through edge N+1.
- Back-to-back reads every cycle are supported, with one result per cycle.
- A write at edge N is visible to a read issued at edge N+1.
- werr is asserted for exactly one cycle, the cycle after the illegal write.
- Reset asserted mid-read: the pending result is discarded, and rvalid stays 0 after rst deasserts until a new re.

## Configuration
- DM_RAW_BYPASS_EN defined:
  - A same-word read and write in one cycle returns the post-write word: the written lanes come from wdata and the remaining lanes from memory.
  - The merge is applied before extraction.
  - Bypass applies only when the write is legal.
- DM_RAW_BYPASS_EN undefined: a same-cycle same-word read returns the pre-write contents (read-first).

## Test plan
- Write word 0x80FF7F01 at addr 0x10, then read at addr 0x10 with each size:
  - lb at addr 0x10: 0x00000001
  - lb at addr 0x12: 0xFFFFFFFF
  - lbu at addr 0x12: 0x000000FF
  - lh at addr 0x12: 0xFFFF80FF
  - lhu at addr 0x12: 0x000080FF
  - lw at addr 0x10: 0x80FF7F01
- Byte-lane writes: sb 0xAA to 0x21, then sh 0xBEEF to 0x22, into a word preloaded with 0x11223344 → lw 0x20 = 0xBEEFAA44.
- Illegal accesses:
  - sh at addr 0x13 leaves memory unchanged and gives werr=1 for one cycle.
  - lw at addr 0x1002 (DEPTH=1024) gives rdata=0, rvalid=1, rerr=1.
- Same-cycle collision: preload 0x00000000 at 0x40, then issue sb 0x5A to 0x41 together with lw at 0x40.
  - With DM_RAW_BYPASS_EN: rdata=0x00005A00.
  - Without it: rdata=0x00000000; a lw at the next cycle returns 0x00005A00.
- Reset mid-stream: issue reads every cycle and assert rst asynchronously between edges.
  - rdata=0 and rvalid=0 immediately.
  - A we asserted while rst=1 does not change memory.
  - After release, the first read returns correct data one cycle later.
- DATA_W=64 build:
  - sd 0x8000000000000001 at 0x8, then ld → same value.
  - lw at 0xC → 0xFFFFFFFF80000000.
  - ld at 0x4 → rerr=1.
